seq_detect_ctrl: RTL and testbench

- Stream controller for the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and serializes them MSB-first into an internal Mealy pattern matcher.
- The pattern and its length are programmable; overlapping matches are counted, and an interrupt is raised at a programmable threshold.
- Sits between the host/bus-side word source and the detection status logic.

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_pattern_matcher.sv | 59 +++++
 rtl/seq_detect_ctrl.sv | 143 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and reset constants for the serial sequence detector.
// Holds the controller state encoding and the power-on pattern configuration.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_t;

  localparam logic [7:0] RST_PATTERN = 8'b00011011;
  localparam int         RST_LEN     = 5;
  localparam int         RST_THRESH  = 1;

endpackage

// File: rtl/seq_pattern_matcher.sv
// Bit-serial Mealy matcher: keeps bit history and fill level, compares the low len bits.
// match_hit is combinational on the current bit; match_pulse is its registered copy.
module seq_pattern_matcher
  import seq_detect_pkg::*;
#(
  parameter int PAT_MAX = 8,
  parameter int LW      = $clog2(PAT_MAX) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_valid,
  input  logic               ser_bit,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LW-1:0]      len,
  input  logic               flush,
  output logic               match_hit,
  output logic               match_pulse
);

  logic [PAT_MAX-1:0] history;
  logic [LW-1:0]      fill;
  logic [PAT_MAX-1:0] window;
  logic [PAT_MAX-1:0] mask;
  logic [LW:0]        fill_inc;

  always_comb begin
    window   = {history[PAT_MAX-2:0], ser_bit};
    fill_inc = {1'b0, fill} + (LW+1)'(1);
    mask     = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (LW'(i) < len);
    end
    // fill_inc counts the bit being presented now, so a pattern of len bits
    // can complete on the len-th bit after a flush.
    match_hit = bit_valid && (len != '0) && (fill_inc >= {1'b0, len}) &&
                (((window ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history     <= '0;
      fill        <= '0;
      match_pulse <= 1'b0;
    end else if (flush) begin
      history     <= '0;
      fill        <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= match_hit;
      if (bit_valid) begin
        history <= window;
        if (fill != LW'(PAT_MAX)) begin
          fill <= fill + LW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit stream controller with programmable pattern, saturating match count and sticky irq.
// Optional SEQ_DETECT_MATCH_POS_EN adds match_pos; in_ready drops while a word is mid-shift.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic                       clk_pulse,
  input  logic                       clear_n,
  input  logic                       cfg_we,
  input  logic [PAT_MAX-1:0]         cfg_pattern,
  input  logic [$clog2(PAT_MAX):0]   cfg_len,
  input  logic [CNT_W-1:0]           cfg_thresh,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       irq_ack,
  output logic                       match_pulse,
  output logic [CNT_W-1:0]           match_count,
  output logic                       irq,
  output logic                       busy,
`ifdef SEQ_DETECT_MATCH_POS_EN
  output logic [$clog2(DATA_W)-1:0]  match_pos,
`endif
  output logic [1:0]                 present_state
);

  localparam int              LW      = $clog2(PAT_MAX) + 1;
  localparam int              IW      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state;
  logic [DATA_W-1:0]    word;
  logic [IW-1:0]        bit_idx;
  logic [PAT_MAX-1:0]   pattern_q;
  logic [LW-1:0]        len_q;
  logic [CNT_W-1:0]     thresh_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 irq_q;

  logic                 cfg_take;
  logic                 accept;
  logic                 match_hit;
  logic [LW-1:0]        len_clamped;
  logic [CNT_W-1:0]     cnt_inc;

  assign in_ready      = (state == IDLE) || ((state == SHIFT) && (bit_idx == '0));
  assign busy          = (state == SHIFT);
  assign present_state = state;
  assign accept        = in_valid && in_ready;
  assign cfg_take      = cfg_we && (state == IDLE);
  assign len_clamped   = (cfg_len > LW'(PAT_MAX)) ? LW'(PAT_MAX) : cfg_len;
  assign cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign match_count   = cnt_q;
  assign irq           = irq_q;

  seq_pattern_matcher #(
    .PAT_MAX (PAT_MAX),
    .LW      (LW)
  ) u_matcher (
    .clk         (clk_pulse),
    .rst_n       (clear_n),
    .bit_valid   (busy),
    .ser_bit     (word[bit_idx]),
    .pattern     (pattern_q),
    .len         (len_q),
    .flush       (cfg_take),
    .match_hit   (match_hit),
    .match_pulse (match_pulse)
  );

  always_ff @(posedge clk_pulse or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      word      <= '0;
      bit_idx   <= '0;
      pattern_q <= PAT_MAX'(RST_PATTERN);
      len_q     <= LW'(RST_LEN);
      thresh_q  <= CNT_W'(RST_THRESH);
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we) begin
            pattern_q <= cfg_pattern;
            len_q     <= len_clamped;
            thresh_q  <= cfg_thresh;
          end
          if (accept) begin
            word    <= in_data;
            bit_idx <= IW'(DATA_W - 1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_idx == '0) begin
            // Last bit of the word: reload without a bubble if another is offered.
            if (in_valid) begin
              word    <= in_data;
              bit_idx <= IW'(DATA_W - 1);
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_idx <= bit_idx - IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pulse or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else if (cfg_take) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else if (irq_ack) begin
      // A match landing with the ack counts as the first match of the new epoch.
      cnt_q <= match_hit ? CNT_W'(1) : '0;
      irq_q <= match_hit && (thresh_q == CNT_W'(1));
    end else if (match_hit) begin
      cnt_q <= cnt_inc;
      if ((thresh_q != '0) && (cnt_q != CNT_MAX) && (cnt_inc == thresh_q)) begin
        irq_q <= 1'b1;
      end
    end
  end

`ifdef SEQ_DETECT_MATCH_POS_EN
  always_ff @(posedge clk_pulse or negedge clear_n) begin
    if (!clear_n) begin
      match_pos <= '0;
    end else if (match_hit) begin
      match_pos <= bit_idx;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl against a bit-queue reference model.
module tb_seq_detect_ctrl;

  localparam int DATA_W  = 8;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 8;

  logic       clk_pulse = 1'b0;
  logic       clear_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic [7:0] cfg_thresh = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       irq_ack = 1'b0;
  logic       match_pulse;
  logic [7:0] match_count;
  logic       irq;
  logic       busy;
  logic [1:0] present_state;
`ifdef SEQ_DETECT_MATCH_POS_EN
  logic [2:0] match_pos;
`endif

  seq_detect_ctrl #(.DATA_W(DATA_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .clk_pulse     (clk_pulse),
    .clear_n       (clear_n),
    .cfg_we        (cfg_we),
    .cfg_pattern   (cfg_pattern),
    .cfg_len       (cfg_len),
    .cfg_thresh    (cfg_thresh),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .irq_ack       (irq_ack),
    .match_pulse   (match_pulse),
    .match_count   (match_count),
    .irq           (irq),
    .busy          (busy),
`ifdef SEQ_DETECT_MATCH_POS_EN
    .match_pos     (match_pos),
`endif
    .present_state (present_state)
  );

  always #5 clk_pulse = ~clk_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model: bits still to be serialized, bits seen since the last flush.
  bit         pend[$];
  bit         hist[$];
  logic [7:0] m_pat;
  int         m_len, m_th, m_cnt, m_pos;
  bit         m_irq, m_pulse;

  int         cyc = 0;
  int         t_acc = 0;
  int         obs_pulses = 0;
  int         pulse_cyc[$];
  bit         pulse_irq[$];

  function automatic bit window_match(input bit q[$]);
    if (m_len == 0 || q.size() < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      if (q[q.size()-1-j] != m_pat[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit peek_match();
    bit q[$];
    q = hist;
    q.push_back(pend[0]);
    return window_match(q);
  endfunction

  task automatic model_reset();
    pend.delete();
    hist.delete();
    m_pat = 8'b00011011; m_len = 5; m_th = 1;
    m_cnt = 0; m_irq = 0; m_pulse = 0; m_pos = 0;
  endtask

  task automatic clear_obs();
    obs_pulses = 0;
    pulse_cyc.delete();
    pulse_irq.delete();
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic step();
    bit busy_pre, rdy_pre, m, b;
    busy_pre = (pend.size() > 0);
    rdy_pre  = (pend.size() <= 1);
    m = 1'b0;
    if (cfg_we && !busy_pre) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
      m_th  = int'(cfg_thresh);
      hist.delete();
    end
    if (busy_pre) begin
      b = pend.pop_front();
      hist.push_back(b);
      if (hist.size() > PAT_MAX) void'(hist.pop_front());
      m = window_match(hist);
      if (m) m_pos = pend.size();
    end
    if (in_valid && rdy_pre) begin
      for (int i = DATA_W-1; i >= 0; i--) pend.push_back(in_data[i]);
    end
    if (cfg_we && !busy_pre) begin
      m_cnt = 0; m_irq = 0;
    end else if (irq_ack) begin
      m_cnt = m ? 1 : 0;
      m_irq = m && (m_th == 1);
    end else if (m && m_cnt < 255) begin
      m_cnt++;
      if (m_th != 0 && m_cnt == m_th) m_irq = 1;
    end
    m_pulse = m;
    @(posedge clk_pulse);
    #1;
    cyc++;
    checks++;
    if (match_pulse !== m_pulse) begin
      errors++; $display("FAIL match_pulse @%0d: got %0b expected %0b", cyc, match_pulse, m_pulse);
    end
    checks++;
    if (match_count !== 8'(m_cnt)) begin
      errors++; $display("FAIL match_count @%0d: got %0d expected %0d", cyc, match_count, m_cnt);
    end
    checks++;
    if (irq !== m_irq) begin
      errors++; $display("FAIL irq @%0d: got %0b expected %0b", cyc, irq, m_irq);
    end
    checks++;
    if (in_ready !== (pend.size() <= 1)) begin
      errors++; $display("FAIL in_ready @%0d: got %0b expected %0b", cyc, in_ready, pend.size() <= 1);
    end
    checks++;
    if (busy !== (pend.size() > 0) || present_state !== ((pend.size() > 0) ? 2'b01 : 2'b00)) begin
      errors++; $display("FAIL state @%0d: got busy=%0b state=%0d expected busy=%0b", cyc, busy, present_state, pend.size() > 0);
    end
`ifdef SEQ_DETECT_MATCH_POS_EN
    checks++;
    if (match_pos !== 3'(m_pos)) begin
      errors++; $display("FAIL match_pos @%0d: got %0d expected %0d", cyc, match_pos, m_pos);
    end
`endif
    if (match_pulse) begin
      obs_pulses++;
      pulse_cyc.push_back(cyc);
      pulse_irq.push_back(irq);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send_word(input logic [7:0] d);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 40; k++) begin
      acc = (pend.size() <= 1);
      step();
      if (acc) begin
        in_valid = 1'b0;
        t_acc = cyc;
        return;
      end
    end
    in_valid = 1'b0;
    checks++; errors++;
    $display("FAIL send_timeout: got no accept, expected accept within 40 cycles");
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && pend.size() > 0; k++) step();
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] th);
    wait_idle();
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_thresh = th;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 0; cfg_we = 0; irq_ack = 0;
    clear_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || present_state !== 2'b00 ||
        match_count !== 8'd0 || irq !== 1'b0 || match_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b busy=%0b st=%0d cnt=%0d irq=%0b pulse=%0b expected 1 0 0 0 0 0",
               in_ready, busy, present_state, match_count, irq, match_pulse);
    end
    @(negedge clk_pulse);
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    idle(3);
  endtask

  task automatic test_default_word();
    do_reset();
    clear_obs();
    send_word(8'b11011011);
    idle(10);
    checks++;
    if (obs_pulses != 2) begin
      errors++; $display("FAIL default_pulses: got %0d expected 2", obs_pulses);
    end else begin
      // Pulses follow the accepting edge by 5 and 8 edges (bit indices 3 and 0).
      checks++;
      if (pulse_cyc[0] - t_acc != 5 || pulse_cyc[1] - t_acc != 8) begin
        errors++; $display("FAIL default_timing: got +%0d,+%0d expected +5,+8", pulse_cyc[0]-t_acc, pulse_cyc[1]-t_acc);
      end
      checks++;
      if (pulse_irq[0] !== 1'b1) begin
        errors++; $display("FAIL default_irq_first: got %0b expected 1", pulse_irq[0]);
      end
    end
    checks++;
    if (match_count !== 8'd2 || irq !== 1'b1) begin
      errors++; $display("FAIL default_final: got cnt=%0d irq=%0b expected 2 1", match_count, irq);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int gaps;
    do_reset();
    clear_obs();
    gaps = 0;
    in_valid = 1'b1; in_data = 8'hFF;
    step();
    in_data = 8'h1B;
    for (int k = 0; k < 20; k++) begin
      acc = (pend.size() <= 1);
      step();
      if (!busy) gaps++;
      if (acc) break;
    end
    in_valid = 1'b0;
    idle(12);
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL b2b_bubble: got %0d idle cycles expected 0", gaps);
    end
    checks++;
    if (match_count !== 8'd1 || obs_pulses != 1) begin
      errors++; $display("FAIL b2b_count: got cnt=%0d pulses=%0d expected 1 1", match_count, obs_pulses);
    end
  endtask

  task automatic test_config();
    do_cfg(8'b00000101, 4'd3, 8'd3);
    clear_obs();
    send_word(8'b10101010);
    idle(10);
    checks++;
    if (obs_pulses != 3 || match_count !== 8'd3 || irq !== 1'b1) begin
      errors++; $display("FAIL cfg_count: got pulses=%0d cnt=%0d irq=%0b expected 3 3 1", obs_pulses, match_count, irq);
    end else begin
      checks++;
      if (pulse_irq[1] !== 1'b0 || pulse_irq[2] !== 1'b1) begin
        errors++; $display("FAIL cfg_irq_edge: got %0b%0b expected 01", pulse_irq[1], pulse_irq[2]);
      end
    end
  endtask

  task automatic test_irq_ack();
    bit acked;
    do_reset();
    clear_obs();
    acked = 0;
    in_valid = 1'b1; in_data = 8'b11011011;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      irq_ack = (obs_pulses == 1) && (pend.size() > 0) && peek_match();
      step();
      if (irq_ack) begin
        acked = 1;
        checks++;
        if (match_count !== 8'd1 || irq !== 1'b1) begin
          errors++; $display("FAIL ack_with_match: got cnt=%0d irq=%0b expected 1 1", match_count, irq);
        end
      end
      irq_ack = 1'b0;
    end
    checks++;
    if (!acked) begin
      errors++; $display("FAIL ack_scenario: got no second match expected one");
    end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    checks++;
    if (match_count !== 8'd0 || irq !== 1'b0) begin
      errors++; $display("FAIL ack_alone: got cnt=%0d irq=%0b expected 0 0", match_count, irq);
    end
  endtask

  task automatic test_cfg_shift_and_reset();
    do_reset();
    in_valid = 1'b1; in_data = 8'h00;
    step();
    in_valid = 1'b0;
    step();
    cfg_we = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd1; cfg_thresh = 8'd0;
    step();
    step();
    cfg_we = 1'b0;
    wait_idle();
    send_word(8'h1B);
    idle(10);
    checks++;
    if (match_count !== 8'd1 || irq !== 1'b1) begin
      errors++; $display("FAIL cfg_in_shift: got cnt=%0d irq=%0b expected 1 1", match_count, irq);
    end
    // Mid-word reset after three bits (1,1,0) so stale history would match "11".
    in_valid = 1'b1; in_data = 8'b11011011;
    step();
    in_valid = 1'b0;
    idle(3);
    do_reset();
    clear_obs();
    send_word(8'b11000000);
    idle(10);
    checks++;
    if (obs_pulses != 0 || match_count !== 8'd0) begin
      errors++; $display("FAIL stale_history: got pulses=%0d cnt=%0d expected 0 0", obs_pulses, match_count);
    end
  endtask

  task automatic test_len0_saturate();
    bit acc;
    int words;
    do_cfg(8'hFF, 4'd0, 8'd1);
    clear_obs();
    send_word(8'hFF);
    idle(10);
    checks++;
    if (obs_pulses != 0 || match_count !== 8'd0) begin
      errors++; $display("FAIL len0: got pulses=%0d cnt=%0d expected 0 0", obs_pulses, match_count);
    end
    do_cfg(8'h01, 4'd1, 8'd0);
    words = 0;
    in_valid = 1'b1; in_data = 8'hFF;
    for (int k = 0; k < 400 && words < 38; k++) begin
      acc = (pend.size() <= 1);
      step();
      if (acc) words++;
    end
    in_valid = 1'b0;
    idle(10);
    checks++;
    if (match_count !== 8'd255 || irq !== 1'b0) begin
      errors++; $display("FAIL saturate: got cnt=%0d irq=%0b expected 255 0", match_count, irq);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_cfg(8'($urandom), 4'($urandom_range(0, 9)), 8'($urandom_range(0, 4)));
      for (int k = 0; k < 150; k++) begin
        in_valid    = ($urandom_range(0, 9) < 7);
        in_data     = 8'($urandom);
        irq_ack     = ($urandom_range(0, 7) == 0);
        cfg_we      = ($urandom_range(0, 19) == 0);
        cfg_pattern = 8'($urandom);
        cfg_len     = 4'($urandom_range(0, 9));
        cfg_thresh  = 8'($urandom_range(0, 4));
        step();
      end
      in_valid = 0; irq_ack = 0; cfg_we = 0;
      wait_idle();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default_word();
    test_back_to_back();
    test_config();
    test_irq_ack();
    test_cfg_shift_and_reset();
    test_len0_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
